// File: rtl/camera_qsys_key_pio_irq.sv
// Avalon-MM key/switch PIO: synchronise, debounce and edge-detect each input,
// latch edges in a write-1-to-clear capture register and raise a masked level irq.
module camera_qsys_key_pio_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_write;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_sync         = r_sync[SYNC_STAGES-1];
    assign w_write        = chipselect & ~write_n;
    assign w_clr          = (w_write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = &{1'b0, writedata};

    // Keys idle high, so the chain resets to 1s and no edge appears on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '1;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= CNT_MAX) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_prev;
    assign w_fall = ~r_stable & r_prev;

    always_comb begin
        w_edge = w_rise | w_fall;
        if (EDGE_TYPE == 0)      w_edge = w_rise;
        else if (EDGE_TYPE == 1) w_edge = w_fall;
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_edge_capture;
            default: w_rd_mux = '0;
        endcase
    end

    // A set and a clear on the same bit in one cycle leave the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev         <= '1;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            irq            <= 1'b0;
            readdata       <= '0;
        end else begin
            r_prev         <= r_stable;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            irq            <= |(r_edge_capture & r_irq_mask);
            readdata       <= w_rd_mux;
            if (w_write && address == 2'd2) r_irq_mask <= writedata[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_camera_qsys_key_pio_irq.sv
// Bench for camera_qsys_key_pio_irq: directed scenarios plus random key/bus traffic,
// every cycle compared against a sample-window reference model.
module tb_camera_qsys_key_pio_irq;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // Reference model state
    logic [W-1:0] m_sync [S];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_stable, m_prev, m_mask, m_ec;
    logic [31:0]  m_rd;
    logic         m_irq;

    camera_qsys_key_pio_irq #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < S; s++) m_sync[s] = '1;
        m_hist = {};
        for (int k = 0; k < D; k++) m_hist.push_back('1);
        m_stable = '1;
        m_prev   = '1;
        m_mask   = '0;
        m_ec     = '0;
        m_rd     = '0;
        m_irq    = 1'b0;
    endtask

    // A key level is accepted once the last D synchronised samples all disagree with it.
    task automatic model_clock();
        logic [W-1:0] s_cur, new_stable, fall, clr;
        logic         wr, all_flip;
        s_cur = m_sync[S-1];
        m_hist.push_back(s_cur);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        new_stable = m_stable;
        for (int b = 0; b < W; b++) begin
            all_flip = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_flip = 1'b0;
            if (all_flip) new_stable[b] = ~m_stable[b];
        end
        fall = m_prev & ~m_stable;
        wr   = chipselect && !write_n;
        clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        case (address)
            2'd0:    m_rd = {28'd0, m_stable};
            2'd2:    m_rd = {28'd0, m_mask};
            2'd3:    m_rd = {28'd0, m_ec};
            default: m_rd = 32'd0;
        endcase
        m_irq = (m_ec & m_mask) != 0;
        m_ec  = (m_ec & ~clr) | fall;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_prev   = m_stable;
        m_stable = new_stable;
        for (int s = S - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
        m_sync[0] = in_port;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_clock();
        exp_q.push_back(m_rd);
        #1;
        check_eq("readdata", readdata, exp_q.pop_front());
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        step();
        d = readdata;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("reset_readdata", readdata, 32'd0);
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        repeat (3) step();
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        bus_idle();
        address = 2'd0;
        in_port = '1;
        assert_reset();
        reset_n = 1'b1;

        bus_read(2'd0, rd); check_eq("init_data", rd, 32'hF);
        bus_read(2'd2, rd); check_eq("init_mask", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("init_cap", rd, 32'h0);
        bus_read(2'd1, rd); check_eq("reserved", rd, 32'h0);

        // Glitch shorter than the debounce window
        in_port[0] = 1'b0;
        repeat (3) step();
        in_port[0] = 1'b1;
        repeat (10) step();
        bus_read(2'd0, rd); check_eq("glitch_data", rd, 32'hF);
        bus_read(2'd3, rd); check_eq("glitch_cap", rd, 32'h0);
        check_eq("glitch_irq", {31'd0, irq}, 32'd0);

        // Valid press with mask enabled
        bus_write(2'd2, 32'h4);
        in_port[2] = 1'b0;
        n = 0;
        while (!irq && n < 20) begin
            step();
            n++;
        end
        check_eq("press_irq_latency_in_7_to_9", {31'd0, (n >= 7 && n <= 9)}, 32'd1);
        repeat (2) step();
        bus_read(2'd0, rd); check_eq("press_data", rd, 32'hB);
        bus_read(2'd3, rd); check_eq("press_cap", rd, 32'h4);
        in_port[2] = 1'b1;
        repeat (12) step();
        bus_read(2'd3, rd); check_eq("release_no_cap", rd, 32'h4);
        bus_read(2'd0, rd); check_eq("release_data", rd, 32'hF);

        // Mask and clear
        bus_write(2'd2, 32'h0);
        step();
        check_eq("unmasked_irq", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h4);
        step();
        check_eq("masked_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h4);
        check_eq("read_during_clear", readdata, 32'h4);
        step();
        check_eq("cleared_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd); check_eq("cleared_cap", rd, 32'h0);

        // Clear of bit 0 lands on the same edge its falling edge is captured
        in_port[0] = 1'b0;
        repeat (6) step();
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd); check_eq("set_beats_clear", rd, 32'h1);
        in_port[0] = 1'b1;
        repeat (10) step();

        // Read latency and mux
        address = 2'd3; step(); check_eq("lat_addr3", readdata, 32'h1);
        address = 2'd0; step(); check_eq("lat_addr0", readdata, 32'hF);
        address = 2'd1; step(); check_eq("lat_addr1", readdata, 32'h0);
        bus_write(2'd3, 32'hF);

        // Reset while a debounce counter is running
        in_port[1] = 1'b0;
        repeat (4) step();
        assert_reset();
        in_port = '1;
        reset_n = 1'b1;
        bus_read(2'd0, rd); check_eq("rst_mid_data", rd, 32'hF);
        bus_read(2'd2, rd); check_eq("rst_mid_mask", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("rst_mid_cap", rd, 32'h0);

        // Random key activity and bus traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(0, W - 1);
                in_port[n] = ~in_port[n];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 4) != 0);
            writedata  = $urandom;
            step();
            check_eq("upper_zero", {4'd0, readdata[31:4]}, 32'd0);
        end
        bus_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/camera_qsys_key_pio_irq.md
Name: camera_qsys_key_pio_irq

Overview:
Parametrised Avalon-MM slave for push-button/switch inputs. Each input bit passes through a synchroniser and a debouncer, then edge detection. Detected edges are latched in an edge-capture register with per-bit interrupt masking, and the block raises a level interrupt to the Qsys interrupt controller. It replaces the plain read-only key PIO in the camera system, so software no longer polls or debounces the keys.

Parameters:
WIDTH, 4, number of input bits (1..32)
SYNC_STAGES, 2, flip-flop synchroniser depth on in_port (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (>=1)
EDGE_TYPE, 1, capture mode: 0 = rising, 1 = falling, 2 = any edge

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  raw asynchronous key inputs
irq  out  1  level interrupt, active-high

Behaviour:
- Reset and clock: reset_n is asynchronous, active-low; the block is clocked on clk rising edge. All state clears on reset.
- Reset values:
  - readdata = 0
  - irq = 0
  - synchroniser stages = all-1s (keys idle high)
  - stable[] = all-1s
  - debounce counters = 0
  - irq_mask = 0
  - edge_capture = 0
- Synchroniser: in_port passes through SYNC_STAGES flops per bit, giving sync[].
- Debounce, per bit, independent:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync[i] still differs, stable[i] <= sync[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable[i].
  - The counter saturates and does not wrap.
- Edge detect: prev[i] holds stable[i] delayed by one cycle.
  - rise = stable & ~prev
  - fall = ~stable & prev
  - edge = rise (EDGE_TYPE 0), fall (1), or rise|fall (2)
- Register map (unused upper bits read 0, writes to them are ignored):
  - addr 0: DATA, read-only, stable[WIDTH-1:0]. Writes are ignored.
  - addr 1: reserved, reads 0.
  - addr 2: IRQ_MASK, R/W, bits [WIDTH-1:0].
  - addr 3: EDGE_CAPTURE, read; write-1-to-clear per bit.
- Write: occurs when chipselect=1 and write_n=0, taking effect at the next clk edge.
- Edge capture, each cycle: edge_capture <= (edge_capture & ~clr) | edge, where clr = writedata bits on a valid write to addr 3. When a set and a clear hit the same bit in the same cycle, the set wins (bit stays 1).
- Read path:
  - readdata <= mux(address) every clk cycle, independent of chipselect, giving fixed 1-cycle read latency.
  - A read of addr 3 in the same cycle as a clear returns the pre-clear value.
- irq: registered, irq <= |(edge_capture & irq_mask). It asserts 1 cycle after the capture bit sets or the mask is written, and deasserts 1 cycle after the clear or unmask.
- Total latency, in_port edge to irq: SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles, ±1 for debounce phase.
- Reset mid-debounce: counters, stable and captures return to their reset values immediately, and no spurious edge is produced on reset release, because prev equals stable at reset.
- Width rule: for WIDTH < 32, readdata[31:WIDTH] = 0.

Test Plan:
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_TYPE=1.
- Reset: assert reset_n=0 mid-run with a counter active -> readdata=0, irq=0; after release, reading addr 0 returns 0xF, addr 2 returns 0, addr 3 returns 0.
- Glitch rejection: pull in_port[0] low for 3 cycles, then high -> DATA stays 0xF, edge_capture stays 0, irq stays 0.
- Valid press:
  - Hold in_port[2] low for ≥8 cycles with mask 0x4 written -> DATA=0xB and edge_capture=0x4.
  - irq=1 within 2+4+2 (±1) cycles of the in_port change.
  - Release in_port[2] -> no new capture (falling mode only).
- Mask and clear:
  - With capture=0x4 and mask=0 -> irq=0.
  - Write mask 0x4 -> irq=1 the next cycle.
  - Write 0x4 to addr 3 -> capture=0 and irq=0 the next cycle.
- Simultaneous set/clear: write 0x1 to addr 3 in the exact cycle bit 0's falling edge is detected -> capture bit 0 reads 1.
- Read latency/mux:
  - Drive address=3 for 1 cycle -> readdata shows the capture value on the following cycle.
  - address=1 -> readdata=0.
  - Upper bits [31:4] are always 0.
